// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit computer.
// Owns PC and IR, runs the memory handshakes and turns control-unit levels into one-cycle strobes.
module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_rdy,
  input  logic [7:0]        i_imem_data,
  output logic [7:0]        o_instr,
  input  logic              i_ctl_regWE,
  input  logic              i_ctl_memWE,
  input  logic              i_ctl_accWE,
  input  logic              i_ctl_lw,
  input  logic              i_ctl_brnch,
  input  logic              i_alu_zero,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  input  logic              i_dmem_rdy,
  output logic              o_reg_we,
  output logic              o_acc_we,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_ir;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_reg_we;
  logic              r_acc_we;
  logic              r_dmem_we;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_br_off;
  logic [CNT_W-1:0]  w_cnt_next;
  state_t            w_retire_state;

  // Branch offset is relative to the branch's own address, so PC is not bumped at fetch.
  assign w_pc_inc       = r_pc + PC_W'(1);
  assign w_br_off       = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};
  assign w_cnt_next     = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_retire_state = i_halt_req ? S_IDLE : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= 8'h00;
      r_cnt     <= '0;
      r_reg_we  <= 1'b0;
      r_acc_we  <= 1'b0;
      r_dmem_we <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      r_acc_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_halt_req && i_start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_imem_rdy) begin
            r_ir    <= i_imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (i_ctl_memWE || i_ctl_lw) begin
            r_dmem_we <= i_ctl_memWE;
            r_state   <= S_MEM;
          end else begin
            if (i_ctl_brnch) begin
              r_pc <= i_alu_zero ? r_pc + w_br_off : w_pc_inc;
            end else begin
              r_pc <= w_pc_inc;
              if (i_ctl_accWE)      r_acc_we <= 1'b1;
              else if (i_ctl_regWE) r_reg_we <= 1'b1;
            end
            r_cnt   <= w_cnt_next;
            r_state <= w_retire_state;
          end
        end
        S_MEM: begin
          if (i_dmem_rdy) begin
            r_dmem_we <= 1'b0;
            if (r_dmem_we) begin
              r_pc    <= w_pc_inc;
              r_cnt   <= w_cnt_next;
              r_state <= w_retire_state;
            end else begin
              r_reg_we <= 1'b1;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc    <= w_pc_inc;
          r_cnt   <= w_cnt_next;
          r_state <= w_retire_state;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_req  = (r_state == S_FETCH);
  assign o_imem_addr = r_pc;
  assign o_instr     = r_ir;
  assign o_dmem_req  = (r_state == S_MEM);
  assign o_dmem_we   = r_dmem_we;
  assign o_reg_we    = r_reg_we;
  assign o_acc_we    = r_acc_we;
  assign o_busy      = (r_state != S_IDLE);
  assign o_instr_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-instruction expectations are queued when driven
// and compared against the cycle-by-cycle observation when the instruction retires.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt_req = 1'b0;
  logic        imem_rdy = 1'b0, dmem_rdy = 1'b0;
  logic [7:0]  imem_data = 8'h00;
  logic        ctl_regWE = 1'b0, ctl_memWE = 1'b0, ctl_accWE = 1'b0, ctl_lw = 1'b0, ctl_brnch = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, dmem_req, dmem_we, reg_we, acc_we, busy;
  logic [7:0]  imem_addr, instr;
  logic [15:0] instr_cnt;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_cnt = 16'h0000;

  typedef struct {
    int         cycles;
    int         reg_we_n;
    int         reg_we_at;
    int         acc_we_n;
    int         dmem_req_n;
    int         dmem_we_n;
    logic [7:0] pc;
    logic [15:0] cnt;
    logic [7:0] ir;
    logic       busy;
  } res_t;

  res_t exp_q[$];

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdy(imem_rdy), .i_imem_data(imem_data),
    .o_instr(instr), .i_ctl_regWE(ctl_regWE), .i_ctl_memWE(ctl_memWE), .i_ctl_accWE(ctl_accWE),
    .i_ctl_lw(ctl_lw), .i_ctl_brnch(ctl_brnch), .i_alu_zero(alu_zero),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_rdy(dmem_rdy),
    .o_reg_we(reg_we), .o_acc_we(acc_we), .o_busy(busy), .o_instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH; returns at the falling edge after retire.
  task automatic run_instr(input logic [7:0] ir, input logic rwe, input logic mwe, input logic awe,
                           input logic lw, input logic br, input logic zero,
                           input int ilat, input int dlat, input logic halt_in_mem, input string tag);
    res_t e, o;
    logic is_mem, is_load;
    int k, ireq, dreq, fk;
    bit fetched, done;
    is_mem  = mwe || lw;
    is_load = lw && !mwe;
    e.ir         = ir;
    e.cycles     = ilat + 2 + (is_mem ? dlat : 0) + (is_load ? 1 : 0);
    e.dmem_req_n = is_mem ? dlat : 0;
    e.dmem_we_n  = mwe ? dlat : 0;
    e.acc_we_n   = (!is_mem && !br && awe) ? 1 : 0;
    e.reg_we_n   = (is_load || (!is_mem && !br && !awe && rwe)) ? 1 : 0;
    e.reg_we_at  = (e.reg_we_n == 0) ? -1 : (is_load ? e.cycles - 1 : e.cycles);
    e.pc         = (br && !is_mem && zero) ? m_pc + {{3{ir[4]}}, ir[4:0]} : m_pc + 8'd1;
    e.cnt        = m_cnt + 16'd1;
    e.busy       = !halt_in_mem;
    exp_q.push_back(e);
    m_pc  = e.pc;
    m_cnt = e.cnt;

    imem_data = ir; ctl_regWE = rwe; ctl_memWE = mwe; ctl_accWE = awe;
    ctl_lw = lw; ctl_brnch = br; alu_zero = zero;
    o = '{cycles: -1, reg_we_n: 0, reg_we_at: -1, acc_we_n: 0, dmem_req_n: 0,
          dmem_we_n: 0, pc: 8'h00, cnt: 16'h0000, ir: 8'h00, busy: 1'b0};
    k = 0; ireq = 0; dreq = 0; fk = 0; fetched = 0; done = 0;
    while (!done && k < 60) begin
      if (k > 0) begin
        if (fetched && k > fk && (imem_req || !busy)) begin
          done = 1; o.cycles = k; o.busy = busy;
        end
        if (reg_we) begin
          o.reg_we_n++;
          if (o.reg_we_at < 0) o.reg_we_at = k;
        end
        if (acc_we) o.acc_we_n++;
        if (reg_we && acc_we) viol++;
        if (imem_req && dmem_req) viol++;
      end
      if (!done) begin
        if (dmem_req) begin
          dreq++;
          if (dmem_we) o.dmem_we_n++;
          if (halt_in_mem) halt_req = 1'b1;
        end
        dmem_rdy = dmem_req && (dreq >= dlat);
        if (imem_req && !fetched) begin
          ireq++;
          imem_rdy = (ireq >= ilat);
          if (imem_rdy) begin fetched = 1; fk = k; end
        end else begin
          imem_rdy = 1'b0;
        end
        if (fetched && k == fk + 1) o.ir = instr;
        @(negedge clk);
        k++;
      end
    end
    imem_rdy = 1'b0; dmem_rdy = 1'b0; halt_req = 1'b0;
    o.dmem_req_n = dreq; o.pc = imem_addr; o.cnt = instr_cnt;

    e = exp_q.pop_front();
    chk({tag, ".cycles"},    o.cycles,     e.cycles);
    chk({tag, ".ir"},        o.ir,         e.ir);
    chk({tag, ".reg_we_n"},  o.reg_we_n,   e.reg_we_n);
    chk({tag, ".reg_we_at"}, o.reg_we_at,  e.reg_we_at);
    chk({tag, ".acc_we_n"},  o.acc_we_n,   e.acc_we_n);
    chk({tag, ".dmem_req"},  o.dmem_req_n, e.dmem_req_n);
    chk({tag, ".dmem_we"},   o.dmem_we_n,  e.dmem_we_n);
    chk({tag, ".pc"},        o.pc,         e.pc);
    chk({tag, ".cnt"},       o.cnt,        e.cnt);
    chk({tag, ".busy"},      o.busy,       e.busy);
    $display("instr %-10s ir=%02h pc=%02h cnt=%0d cycles=%0d", tag, ir, o.pc, o.cnt, o.cycles);
  endtask

  // Walks the PC to target with taken branches of at most -16..+15.
  task automatic goto_pc(input logic [7:0] target);
    int d;
    logic [4:0] off;
    for (int n = 0; n < 40 && m_pc != target; n++) begin
      d = int'(target) - int'(m_pc);
      if (d > 127) d -= 256;
      if (d < -128) d += 256;
      if (d > 15) d = 15;
      if (d < -16) d = -16;
      off = 5'(d);
      run_instr({3'b100, off}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, "goto");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.imem_req", imem_req, 1'b0);
    chk("rst.dmem_req", dmem_req, 1'b0);
    chk("rst.dmem_we",  dmem_we,  1'b0);
    chk("rst.reg_we",   reg_we,   1'b0);
    chk("rst.acc_we",   acc_we,   1'b0);
    chk("rst.busy",     busy,     1'b0);
    chk("rst.pc",       imem_addr, 8'h00);
    chk("rst.ir",       instr,    8'h00);
    chk("rst.cnt",      instr_cnt, 16'h0000);

    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start.imem_req", imem_req, 1'b1);
    chk("start.addr",     imem_addr, 8'h00);

    #2 rst_n = 1'b0;
    #1;
    chk("midfetch_rst.imem_req", imem_req, 1'b0);
    chk("midfetch_rst.busy",     busy,     1'b0);
    chk("midfetch_rst.pc",       imem_addr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("release.imem_req", imem_req, 1'b1);
    chk("release.addr",     imem_addr, 8'h00);

    run_instr(8'b010_00011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, "alu");
    run_instr(8'b111_00010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 1'b0, "load");
    run_instr(8'b110_00001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "store");
    run_instr(8'b001_00101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, "acc");
    run_instr(8'b000_00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, "nop_slow");

    goto_pc(8'h10);
    run_instr(8'b100_11110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, "br_taken");
    goto_pc(8'h10);
    run_instr(8'b100_11110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, "br_nt");
    goto_pc(8'hFF);
    run_instr(8'b100_11110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, "br_wrap");

    run_instr(8'b111_00100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1'b1, "load_halt");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halted.imem_req", imem_req, 1'b0);
    end
    halt_req = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("halt_prio.busy", busy, 1'b0);
    end
    halt_req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("resume.imem_req", imem_req, 1'b1);
    chk("resume.addr",     imem_addr, m_pc);
    run_instr(8'b010_00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, "alu_resume");

    chk("strobe_exclusive", viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit computer.
- Owns the PC and the instruction register (IR). The IR drives the combinational control unit.
- Converts the control unit's level-type enables (regWE, memWE, accWE, lw, brnch) into single-cycle write strobes at the correct phase.
- Runs instruction-memory and data-memory req/rdy handshakes, which allows multi-cycle memories.

Parameters:
- PC_W, 8, program counter width in bits.
- RESET_PC, 8'h00, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching (level, sampled in IDLE).
- halt_req  in  1  stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rdy  in  1  fetch data valid this cycle.
- imem_data  in  8  fetched instruction.
- instr  out  8  IR contents, routed to the control unit.
- ctl_regWE  in  1  control unit regWE.
- ctl_memWE  in  1  control unit memWE.
- ctl_accWE  in  1  control unit accWE.
- ctl_lw  in  1  control unit lw.
- ctl_brnch  in  1  control unit brnch.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- dmem_rdy  in  1  data memory access complete.
- reg_we  out  1  register-file write strobe (1 cycle).
- acc_we  out  1  accumulator write strobe (1 cycle).
- busy  out  1  high in any state except IDLE.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, IR=8'h00, instr_cnt=0.
  - All strobes and reqs are 0; busy=0.
- State register encodes IDLE, FETCH, DECODE, EXEC, MEM, WB. All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- IDLE:
  - start=1 → FETCH.
  - halt_req has priority over start.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_rdy=1: IR<=imem_data, → DECODE.
  - Otherwise hold with req asserted indefinitely.
  - Minimum fetch cost is 1 cycle, when rdy returns in the same cycle as req.
- DECODE: exactly one cycle so the control unit outputs settle on the new IR; → EXEC.
- EXEC: decided by control inputs, priority top-down:
  - ctl_memWE or ctl_lw → MEM.
  - ctl_brnch: if alu_zero=1, pc<=pc+sext(IR[4:0]); else pc<=pc+1. Retire.
  - ctl_accWE: acc_we=1 for this one cycle, pc<=pc+1. Retire.
  - ctl_regWE (with lw=0): reg_we=1 for this one cycle, pc<=pc+1. Retire.
  - None asserted: treat as NOP, pc<=pc+1. Retire.
- MEM:
  - dmem_req=1, dmem_we=ctl_memWE (IR is stable, so the value is stable).
  - Hold until dmem_rdy=1.
  - On rdy: a store retires with pc<=pc+1; a load → WB.
- WB: reg_we=1 for one cycle, pc<=pc+1. Retire.
- Retire:
  - instr_cnt += 1, saturating at all-ones.
  - Next state is IDLE if halt_req=1 in the retire cycle, else FETCH.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 → 0x00. Branch offsets are two's-complement −16..+15 relative to the branch instruction's own address, wrapping.
- Minimum cycles per instruction:
  - ALU/acc/branch: 3 (FETCH, DECODE, EXEC).
  - Store: 4.
  - Load: 5.
- halt_req asserted mid-instruction never aborts the instruction. It only takes effect at retire.
- Reset asserted mid-handshake drops imem_req/dmem_req immediately (async).
- reg_we and acc_we are never both high. dmem_req and imem_req are never both high.

Test Plan:
- Reset: hold rst_n=0 mid-FETCH → req=0, pc=0x00, state IDLE. Release with start=1 → imem_req=1 and imem_addr=0x00 on the next edge.
- ALU op, imem_rdy tied 1: IR=8'b010_00011 with ctl_regWE=1 → reg_we pulses exactly 1 cycle, 3 cycles after FETCH entry. pc 0x00→0x01. instr_cnt=1.
- Load with dmem_rdy delayed 4 cycles: IR=8'b111_00010, ctl_lw=1.
  - dmem_req stays high for 4 cycles with dmem_we=0.
  - reg_we pulses in WB, not in MEM.
  - Total 8 cycles; pc +1.
- Store, rdy immediate: ctl_memWE=1 → dmem_we=1 for 1 cycle, no reg_we, pc +1.
- Branch, at pc=0x10:
  - IR[4:0]=5'b11110 with alu_zero=1 → pc=0x0E.
  - Same IR with alu_zero=0 → pc=0x11.
  - At pc=0xFF not taken → pc=0x00.
- Halt: assert halt_req during MEM of a load → load completes (reg_we pulses), state=IDLE, busy=0, no further imem_req. start=1 resumes at pc+1.
